fetch_unit: RTL and testbench

//  Instruction fetch stage. Produces the {hit, pc, inst} stream that the ID-stage decoder consumes.

---
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Purpose: IF stage; assembles 32-bit little-endian instructions from four byte reads
//          and presents {hit, pc, inst} to the ID decoder; takes EX redirects.
// Latency: 9 cycles per instruction uncontended (4x REQ+WAIT, 1x OUT); 2 cycles on I-cache hit.
// Backpressure: stall holds hit/pc/inst in S_OUT with no memory traffic; rdy=0 freezes all state.
// Optional feature macro: IF_ICACHE_EN (direct-mapped I-cache, ICACHE_LINES words).
// Ports: clk, rst_n (sync, active-low), rdy, stall, jump_en/jump_addr (redirect),
//        mem_req/mem_addr/mem_gnt/mem_rvalid/mem_rdata (8-bit read port), hit/pc/inst (to ID).
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_LINES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        stall,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [7:0]  mem_rdata,
    output logic        hit,
    output logic [31:0] pc,
    output logic [31:0] inst
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    // Cache indexing relies on a power-of-two depth.
    if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
        $error("fetch_unit: ICACHE_LINES must be a power of 2 and >= 2");
    end

    logic [1:0]  state;
    logic [1:0]  byte_idx;
    logic [31:0] fetch_pc;
    // Only bytes 0..2 are buffered; byte 3 goes straight into inst together
    // with the buffer so inst is never seen partially updated.
    logic [23:0] inst_buf;

    logic        cache_hit;
    logic [31:0] cache_word;

`ifdef IF_ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ICACHE_LINES-1:0] c_valid;
    logic [TAG_W-1:0]        c_tag  [ICACHE_LINES];
    logic [31:0]             c_data [ICACHE_LINES];
    logic [IDX_W-1:0]        c_idx;
    logic [TAG_W-1:0]        c_tag_in;
    logic                    c_fill;

    assign c_idx      = fetch_pc[2 +: IDX_W];
    assign c_tag_in   = fetch_pc[31 -: TAG_W];
    // Lookup only at the start of a word; a partially fetched word keeps the byte path.
    assign cache_hit  = (state == S_REQ) && (byte_idx == 2'd0) &&
                        c_valid[c_idx] && (c_tag[c_idx] == c_tag_in);
    assign cache_word = c_data[c_idx];
    // Fill when the last byte lands; a same-cycle redirect cancels it.
    assign c_fill     = rst_n && rdy && !jump_en && (state == S_WAIT) &&
                        mem_rvalid && (byte_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_valid <= '0;
        end else if (c_fill) begin
            c_valid[c_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (c_fill) begin
            c_tag[c_idx]  <= c_tag_in;
            c_data[c_idx] <= {mem_rdata, inst_buf};
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_word = 32'h0000_0000;
`endif

    // Request is held off while rst_n is low so the port is quiet during reset.
    assign mem_req  = rst_n && (state == S_REQ) && !cache_hit;
    assign mem_addr = fetch_pc + {30'd0, byte_idx};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_REQ;
            byte_idx <= 2'd0;
            fetch_pc <= RESET_PC;
            inst_buf <= 24'd0;
            hit      <= 1'b0;
            pc       <= RESET_PC;
            inst     <= 32'd0;
        end else if (rdy) begin
            if (jump_en) begin
                // Redirect wins over stall and over any byte arriving this cycle.
                fetch_pc <= {jump_addr[31:2], 2'b00};
                byte_idx <= 2'd0;
                state    <= S_REQ;
                hit      <= 1'b0;
            end else begin
                case (state)
                    S_REQ: begin
                        if (cache_hit) begin
                            state <= S_OUT;
                            hit   <= 1'b1;
                            pc    <= fetch_pc;
                            inst  <= cache_word;
                        end else if (mem_gnt) begin
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (mem_rvalid) begin
                            if (byte_idx == 2'd3) begin
                                state <= S_OUT;
                                hit   <= 1'b1;
                                pc    <= fetch_pc;
                                inst  <= {mem_rdata, inst_buf};
                            end else begin
                                inst_buf[{byte_idx, 3'b000} +: 8] <= mem_rdata;
                                byte_idx <= byte_idx + 2'd1;
                                state    <= S_REQ;
                            end
                        end
                    end
                    S_OUT: begin
                        if (!stall) begin
                            fetch_pc <= fetch_pc + 32'd4;
                            byte_idx <= 2'd0;
                            state    <= S_REQ;
                            hit      <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_REQ;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: self-checking bench for fetch_unit with a byte-wide memory model.
// Latency: memory grants after gnt_lat cycles of request, data 1 cycle after grant.
// Backpressure: stall/rdy driven directly by the directed sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n, rdy, stall, jump_en;
    logic [31:0] jump_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        hit;
    logic [31:0] pc, inst;

    int          total = 0;
    int          bad   = 0;
    int          gnt_lat = 0;
    int          wcnt = 0;
    logic        hs = 1'b0;
    logic [31:0] hs_addr = 32'd0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rdy        (rdy),
        .stall      (stall),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .hit        (hit),
        .pc         (pc),
        .inst       (inst)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0513;
            32'h0000_0004: return 32'h00A0_0593;
            32'h0000_0040: return 32'h0BAD_C0DE;
            32'h0000_0044: return 32'h1122_3344;
            32'h0000_0200: return 32'hCAFE_F00D;
            32'h0000_1000: return 32'h1234_5678;
            32'h0000_2000: return 32'hA1B2_C3D4;
            32'hFFFF_FFFC: return 32'hDEAD_BEEF;
            default:       return a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] w;
        w = word_at({a[31:2], 2'b00});
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    // Memory model: grant decided mid-cycle, data returned the cycle after the grant.
    always @(negedge clk) begin
        if (mem_req && rdy && rst_n) begin
            if (wcnt >= gnt_lat) begin
                mem_gnt = 1'b1;
                hs      = 1'b1;
                hs_addr = mem_addr;
                wcnt    = 0;
            end else begin
                mem_gnt = 1'b0;
                hs      = 1'b0;
                wcnt    = wcnt + 1;
            end
        end else begin
            mem_gnt = (gnt_lat == 0);
            hs      = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        mem_rvalid = hs;
        mem_rdata  = hs ? byte_at(hs_addr) : 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_hit(input int maxc, output int n);
        n = 0;
        do begin
            tick();
            n = n + 1;
        end while (!hit && n < maxc);
        if (!hit) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL hit_timeout: got hit=0 after %0d cycles expected hit=1", n);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        int          lat;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;

        vecs[0] = '{32'h0000_0040, 0, 32'h0000_0040, 32'h0BAD_C0DE, 8};
        vecs[1] = '{32'h0000_2003, 0, 32'h0000_2000, 32'hA1B2_C3D4, 8};
        vecs[2] = '{32'h0000_0200, 3, 32'h0000_0200, 32'hCAFE_F00D, 20};
        vecs[3] = '{32'h0000_0044, 2, 32'h0000_0044, 32'h1122_3344, 16};
        vecs[4] = '{32'hFFFF_FFFE, 1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 12};

        rst_n = 1'b0; rdy = 1'b1; stall = 1'b1; jump_en = 1'b0; jump_addr = 32'd0;
        gnt_lat = 0;
        tick();
        tick();

        // Reset state
        chk("rst_hit", {31'd0, hit}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);

        // First instruction: byte requests 0..3, hit on cycle 9
        rst_n = 1'b1;
        #1;
        for (int c = 1; c <= 8; c++) begin
            chk("boot_req", {31'd0, mem_req}, {31'd0, c[0]});
            if (c[0]) chk("boot_addr", mem_addr, 32'((c - 1) / 2));
            chk("boot_hit", {31'd0, hit}, 32'd0);
            tick();
        end
        chk("boot_hit9", {31'd0, hit}, 32'd1);
        chk("boot_pc", pc, 32'd0);
        chk("boot_inst", inst, 32'h0000_0513);

        // Stall hold for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hit", {31'd0, hit}, 32'd1);
            chk("stall_pc", pc, 32'd0);
            chk("stall_inst", inst, 32'h0000_0513);
            chk("stall_req", {31'd0, mem_req}, 32'd0);
        end

        // rdy=0 freezes the held output even with stall released
        stall = 1'b0;
        rdy   = 1'b0;
        tick();
        tick();
        chk("rdy_hold_hit", {31'd0, hit}, 32'd1);
        chk("rdy_hold_pc", pc, 32'd0);
        rdy = 1'b1;
        tick();
        chk("release_hit", {31'd0, hit}, 32'd0);
        chk("release_req", {31'd0, mem_req}, 32'd1);
        chk("release_addr", mem_addr, 32'd4);

        // Redirect during byte-2 wait discards the partial word
        for (int i = 0; i < 5; i++) tick();
        chk("b2wait_req", {31'd0, mem_req}, 32'd0);
        chk("b2wait_rvalid", {31'd0, mem_rvalid}, 32'd1);
        jump_en = 1'b1; jump_addr = 32'h0000_1003; stall = 1'b1;
        tick();
        jump_en = 1'b0;
        chk("jmp_hit", {31'd0, hit}, 32'd0);
        chk("jmp_addr", mem_addr, 32'h0000_1000);
        chk("jmp_req", {31'd0, mem_req}, 32'd1);
        wait_hit(60, n);
        chk("jmp_pc", pc, 32'h0000_1000);
        chk("jmp_inst", inst, 32'h1234_5678);
        chk("jmp_cycles", n, 32'd8);

        // Table: redirect targets with varying grant latency
        for (int v = 0; v < 5; v++) begin
            jump_en = 1'b1; jump_addr = vecs[v].addr; gnt_lat = vecs[v].lat;
            tick();
            jump_en = 1'b0;
            chk("vec_bubble", {31'd0, hit}, 32'd0);
            wait_hit(100, n);
            chk("vec_pc", pc, vecs[v].exp_pc);
            chk("vec_inst", inst, vecs[v].exp_inst);
            chk("vec_cycles", n, vecs[v].exp_cyc);
        end

        // fetch_pc wraps from FFFF_FFFC to 0
        stall = 1'b0;
        gnt_lat = 0;
        tick();
        chk("wrap_addr", mem_addr, 32'd0);
        chk("wrap_hit", {31'd0, hit}, 32'd0);

        // Reset mid-fetch
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_hit", {31'd0, hit}, 32'd0);
        chk("midrst_addr", mem_addr, 32'd0);
        chk("midrst_req", {31'd0, mem_req}, 32'd0);
        rst_n = 1'b1;
        stall = 1'b1;
        wait_hit(60, n);
        chk("midrst_pc", pc, 32'd0);
        chk("midrst_inst", inst, 32'h0000_0513);
        chk("midrst_cycles", n, 32'd8);

`ifdef IF_ICACHE_EN
        // Second pass over 0x0/0x4 served from the cache
        stall = 1'b0;
        tick();
        stall = 1'b1;
        wait_hit(60, n);
        chk("c_fill_pc", pc, 32'd4);
        jump_en = 1'b1; jump_addr = 32'd0;
        tick();
        jump_en = 1'b0; stall = 1'b0;
        chk("c_req0", {31'd0, mem_req}, 32'd0);
        chk("c_hit0_lo", {31'd0, hit}, 32'd0);
        tick();
        chk("c_hit0", {31'd0, hit}, 32'd1);
        chk("c_pc0", pc, 32'd0);
        chk("c_inst0", inst, 32'h0000_0513);
        tick();
        chk("c_hit4_lo", {31'd0, hit}, 32'd0);
        chk("c_req4", {31'd0, mem_req}, 32'd0);
        chk("c_addr4", mem_addr, 32'd4);
        tick();
        chk("c_hit4", {31'd0, hit}, 32'd1);
        chk("c_pc4", pc, 32'd4);
        chk("c_inst4", inst, 32'h00A0_0593);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
